clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider. Successor to the fixed single-output DIV_BY divider.
- Each of CHANNELS outputs divides i_clk by a runtime-writable integer N ≥ 2, with exact 50% duty for both odd and even N.
- Adds per-channel enable, glitch-free divisor update, a single-cycle tick per period, and a global phase-align pulse.
- Sits between the board clock (50 MHz) and GPIO or downstream logic that needs derived clocks or strobes.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16)
- DIV_W, 8, width of each divisor register
- DEFAULT_DIV, 7, divisor loaded into every channel at reset (must be ≥ 2 and < 2^DIV_W)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_en  in  CHANNELS  per-channel run enable
- i_div_wr  in  1  divisor write strobe, single cycle
- i_div_sel  in  max(1,$clog2(CHANNELS))  channel index for the write
- i_div_data  in  DIV_W  new divisor N
- o_div_ack  out  1  one-cycle pulse, write accepted
- o_div_err  out  1  one-cycle pulse, write rejected
- i_sync  in  1  one-cycle phase-align pulse for all channels
- o_clk  out  CHANNELS  divided clocks
- o_tick  out  CHANNELS  one-i_clk-cycle strobe per divided period

Behaviour:
- Reset (async, any time, including mid-period):
  - Clears counters, pos/neg phase flops, pending flags, o_tick, o_div_ack and o_div_err to 0; o_clk goes low immediately.
  - Active and shadow divisors both load DEFAULT_DIV.
- Per-channel state:
  - cnt (DIV_W bits) counts 0..N-1 and wraps to 0.
  - active div N, shadow div S, pending flag P.
- Write handshake:
  - i_div_wr sampled on posedge.
  - Accepted when i_div_sel < CHANNELS and 2 ≤ i_div_data: S ← data, P ← 1, o_div_ack = 1 the next cycle.
  - Otherwise nothing changes and o_div_err = 1 the next cycle.
  - A second write to a channel with P=1 overwrites S; last write wins.
- Divisor switch: applied only at a period boundary. When cnt = N-1 and P = 1, the next cycle has N ← S, P ← 0, cnt ← 0. Never mid-period, so no runt pulses.
- Waveform: pos_hi is a posedge flop, neg_hi a negedge flop copying pos_hi.
  - Even N: pos_hi = (cnt < N/2); o_clk = pos_hi. High for N/2 cycles, low for N/2.
  - Odd N: pos_hi = (cnt < (N-1)/2); o_clk = pos_hi | neg_hi. High for N/2 cycles (half-cycle resolution), low for the remainder.
  - In both cases the o_clk rising edge coincides with the i_clk posedge that starts cnt = 0.
- Tick: o_tick[k] is high during the i_clk cycle in which cnt = 0 while enabled, i.e. one cycle every N.
- Enable:
  - i_en[k] = 0: cnt held at 0; o_clk[k] and o_tick[k] low; neg flop cleared on its next negedge.
  - Writes still accepted while disabled. A pending S is applied immediately while disabled, since cnt is idle.
  - On the first posedge with i_en[k] = 1: cnt = 0, o_clk rises, o_tick pulses.
  - Deassertion mid-period truncates the period at the next posedge.
- i_sync: every enabled channel gets cnt ← 0 on the next posedge and applies any pending S at the same time. Rising edges of all enabled channels align.
- Simultaneous events:
  - Write plus sync in the same cycle: the write lands in S and is applied at the following boundary, not by this sync.
  - Sync plus natural wrap: identical result, cnt ← 0.
- Latency: all outputs are registered; no combinational path from inputs to o_clk/o_tick, except the OR of two flops for odd N.

Test Plan:
- Reset then i_en=4'b0001, default N=7, 20 ns i_clk:
  - o_clk[0] period 140 ns, high 70 ns exactly;
  - o_tick[0] pulses every 7 cycles, 20 ns wide.
- Write sel=1, data=4 with channel 1 running at N=7:
  - o_div_ack pulses once;
  - current 7-cycle period completes intact, then 80 ns period with 40/40 duty.
- Error writes: data=1, then sel=5 with CHANNELS=4 -> o_div_err pulses each time; divisors unchanged.
- Channels at N=3, 5, 6, all enabled at staggered times, then i_sync -> next cycle all rising edges coincide; periods 60/100/120 ns, highs 30/50/60 ns.
- Two writes to channel 2 (9, then 10) before its boundary -> only N=10 takes effect; one ack per write.
- Assert i_rst mid-high-phase of channel 0 -> o_clk drops within the same timestep; after release, N=7 again; first rise on the first enabled posedge.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: exact 50% duty for odd and even N,
// per-channel enable, boundary-synchronous divisor update, tick strobe and global phase align.
module clk_div_multi #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 7,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CHANNELS-1:0] i_en,
  input  logic                i_div_wr,
  input  logic [SEL_W-1:0]    i_div_sel,
  input  logic [DIV_W-1:0]    i_div_data,
  output logic                o_div_ack,
  output logic                o_div_err,
  input  logic                i_sync,
  output logic [CHANNELS-1:0] o_clk,
  output logic [CHANNELS-1:0] o_tick
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CHANNELS);

  logic wr_ok;

  assign wr_ok = i_div_wr && ({1'b0, i_div_sel} < CH_LIM) && (i_div_data >= DIV_MIN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_div_ack <= 1'b0;
      o_div_err <= 1'b0;
    end else begin
      o_div_ack <= wr_ok;
      o_div_err <= i_div_wr && !wr_ok;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_act, div_shd, div_nxt;
    logic             pend, run, pos_hi, neg_hi, tick;
    logic             hit, boundary, apply;

    assign hit = wr_ok && (i_div_sel == SEL_W'(k));

    // A period boundary is the natural wrap, a sync pulse, or the first enabled edge.
    always_comb begin
      boundary = !run || i_sync || (cnt == (div_act - ONE));
      apply    = pend && (!i_en[k] || boundary);
      div_nxt  = apply ? div_shd : div_act;
      cnt_nxt  = (!i_en[k] || boundary) ? '0 : (cnt + ONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt     <= '0;
        div_act <= DIV_RST;
        div_shd <= DIV_RST;
        pend    <= 1'b0;
        run     <= 1'b0;
        pos_hi  <= 1'b0;
        tick    <= 1'b0;
      end else begin
        run     <= i_en[k];
        cnt     <= cnt_nxt;
        div_act <= div_nxt;
        // floor(N/2) serves both parities; odd N gains its extra half cycle from neg_hi.
        pos_hi  <= i_en[k] && (cnt_nxt < (div_nxt >> 1));
        tick    <= i_en[k] && (cnt_nxt == '0);
        if (hit) begin
          div_shd <= i_div_data;
          pend    <= 1'b1;
        end else if (apply) begin
          pend    <= 1'b0;
        end
      end
    end

    // Half-cycle stretch, only active for odd divisors.
    always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) neg_hi <= 1'b0;
      else       neg_hi <= pos_hi & div_act[0];
    end

    assign o_clk[k]  = pos_hi | neg_hi;
    assign o_tick[k] = tick;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: half-cycle sampled waveforms compared to hand-written patterns.
module tb_clk_div_multi;

  // Five channels so the 3-bit select can carry an out-of-range index (5).
  localparam int CH = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          div_wr;
  logic [2:0]    div_sel;
  logic [7:0]    div_data;
  logic          div_ack, div_err;
  logic          sync;
  logic [CH-1:0] dclk, dtick;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] cap_clk [CH];
  logic [63:0] cap_tick [CH];
  logic [63:0] cap_ack, cap_err;
  logic        a, e;

  clk_div_multi #(.CHANNELS(CH), .DIV_W(8), .DEFAULT_DIV(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_div_wr(div_wr), .i_div_sel(div_sel),
    .i_div_data(div_data), .o_div_ack(div_ack), .o_div_err(div_err), .i_sync(sync),
    .o_clk(dclk), .o_tick(dtick)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Samples every output 1 ns after each clock edge, starting at the next posedge.
  // The first sample lands in bit nh-1.
  task automatic cap(input int nh);
    for (int c = 0; c < CH; c++) begin
      cap_clk[c]  = '0;
      cap_tick[c] = '0;
    end
    cap_ack = '0;
    cap_err = '0;
    @(posedge clk); #1;
    for (int i = 0; i < nh; i++) begin
      for (int c = 0; c < CH; c++) begin
        cap_clk[c]  = {cap_clk[c][62:0], dclk[c]};
        cap_tick[c] = {cap_tick[c][62:0], dtick[c]};
      end
      cap_ack = {cap_ack[62:0], div_ack};
      cap_err = {cap_err[62:0], div_err};
      if (i < nh - 1) begin
        if (i % 2 == 0) @(negedge clk);
        else            @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wr_div(input logic [2:0] sel, input logic [7:0] data,
                        output logic ack, output logic err);
    @(negedge clk);
    div_wr = 1'b1; div_sel = sel; div_data = data;
    @(posedge clk); #1;
    ack = div_ack;
    err = div_err;
    @(negedge clk);
    div_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; div_wr = 1'b0; div_sel = '0; div_data = '0; sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_clk",  {59'b0, dclk},  64'h0);
    check_eq("rst_tick", {59'b0, dtick}, 64'h0);
    check_eq("rst_ack",  {63'b0, div_ack}, 64'h0);
    check_eq("rst_err",  {63'b0, div_err}, 64'h0);
    @(negedge clk); rst = 1'b0;

    // Default N=7 on channel 0: 7 halves high, 7 low; tick one cycle in seven.
    @(negedge clk); en = 5'b00001;
    cap(28);
    check_eq("n7_clk0",  cap_clk[0],  {2{14'b11111110000000}});
    check_eq("n7_tick0", cap_tick[0], {2{14'b11000000000000}});
    check_eq("n7_idle1", cap_clk[1],  64'h0);

    // Channel 1 starts at N=7, gets N=4 one cycle in; the 7-cycle period finishes first.
    @(negedge clk); en[1] = 1'b1;
    fork
      cap(30);
      begin
        @(negedge clk); div_wr = 1'b1; div_sel = 3'd1; div_data = 8'd4;
        @(negedge clk); div_wr = 1'b0;
      end
    join
    check_eq("sw_clk1",  cap_clk[1],  {14'b11111110000000, 8'b11110000, 8'b11110000});
    check_eq("sw_tick1", cap_tick[1], {14'b11000000000000, 8'b11000000, 8'b11000000});
    check_eq("sw_ack",   cap_ack, {2'b00, 2'b11, 26'b0});
    check_eq("sw_err",   cap_err, 64'h0);

    // Rejected writes: divisor below 2, and an out-of-range channel index.
    wr_div(3'd2, 8'd1, a, e);
    check_eq("bad_div_err", {63'b0, e}, 64'h1);
    check_eq("bad_div_ack", {63'b0, a}, 64'h0);
    @(posedge clk); #1;
    check_eq("err_one_cyc", {63'b0, div_err}, 64'h0);
    wr_div(3'd5, 8'd3, a, e);
    check_eq("bad_sel_err", {63'b0, e}, 64'h1);
    check_eq("bad_sel_ack", {63'b0, a}, 64'h0);
    @(negedge clk); en[2] = 1'b1;
    cap(14);
    check_eq("keep7_clk2", cap_clk[2], 14'b11111110000000);
    @(negedge clk); en[2] = 1'b0;

    // N=3/5/6 on idle channels, staggered enables, then one sync pulse.
    wr_div(3'd2, 8'd3, a, e);
    check_eq("ack_n3", {63'b0, a}, 64'h1);
    wr_div(3'd3, 8'd5, a, e);
    check_eq("ack_n5", {63'b0, a}, 64'h1);
    wr_div(3'd4, 8'd6, a, e);
    check_eq("ack_n6", {63'b0, a}, 64'h1);
    @(negedge clk); en[2] = 1'b1;
    repeat (2) @(negedge clk); en[3] = 1'b1;
    repeat (3) @(negedge clk); en[4] = 1'b1;
    repeat (2) @(negedge clk); sync = 1'b1;
    fork
      cap(24);
      begin @(negedge clk); sync = 1'b0; end
    join
    check_eq("sync_clk2",  cap_clk[2],  {4{6'b111000}});
    check_eq("sync_clk3",  cap_clk[3],  {10'b1111100000, 10'b1111100000, 4'b1111});
    check_eq("sync_clk4",  cap_clk[4],  {2{12'b111111000000}});
    check_eq("sync_tick2", cap_tick[2], {4{6'b110000}});
    check_eq("sync_tick3", cap_tick[3], {10'b1100000000, 10'b1100000000, 4'b1100});
    check_eq("sync_tick4", cap_tick[4], {2{12'b110000000000}});

    // Channel 2 (N=3) gets 9 then 10 inside one period; only 10 lands at the boundary.
    @(negedge clk); sync = 1'b1;
    fork
      cap(30);
      begin
        @(negedge clk); sync = 1'b0; div_wr = 1'b1; div_sel = 3'd2; div_data = 8'd9;
        @(negedge clk); div_data = 8'd10;
        @(negedge clk); div_wr = 1'b0;
      end
    join
    check_eq("lastwr_clk2",  cap_clk[2],  {6'b111000, 20'b11111111110000000000, 4'b1111});
    check_eq("lastwr_tick2", cap_tick[2], {6'b110000, 20'b11000000000000000000, 4'b1100});
    check_eq("lastwr_ack",   cap_ack, {2'b00, 4'b1111, 24'b0});

    // Reset during channel 0's high phase, then restart with only channel 0 enabled.
    @(negedge clk); sync = 1'b1;
    @(negedge clk); sync = 1'b0;
    check_eq("pre_rst_clk0", {63'b0, dclk[0]}, 64'h1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_clk",  {59'b0, dclk},  64'h0);
    check_eq("async_rst_tick", {59'b0, dtick}, 64'h0);
    en = 5'b00001;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    cap(28);
    check_eq("post_rst_clk0",  cap_clk[0],  {2{14'b11111110000000}});
    check_eq("post_rst_tick0", cap_tick[0], {2{14'b11000000000000}});
    check_eq("post_rst_clk2",  cap_clk[2],  64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
